// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module : cpu_pkg
// Brief  : Shared constants for the CPU front end. The fetch stage and its
//          skid buffer take their parameter defaults from here.
// Rev    : 1.0  initial release
// ============================================================================
package cpu_pkg;

   localparam int          CPU_ADDR_W   = 16;
   localparam int          CPU_INST_W   = 32;
   localparam logic [15:0] CPU_RESET_PC = 16'h0000;

   // Encoding of the "no instruction" value held in the output register.
   localparam logic [31:0] NOP_INST     = 32'h0000_0000;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/fetch_skid_buf.sv
`default_nettype none
// ============================================================================
// Module : fetch_skid_buf
// Brief  : One-entry {instruction, pc} holding buffer. It catches the ROM
//          response that lands while decode is stalled.
// Ports  : clk, reset       - clock / async active-high reset
//          clear            - discard content (highest priority)
//          load             - capture load_data/load_pc, set full
//          drain            - content consumed, clear full
//          load_data/pc     - entry to capture
//          data/pc/full     - stored entry and occupancy flag
// Rev    : 1.0  initial release
// ============================================================================
module fetch_skid_buf
   import cpu_pkg::*;
#(
   parameter int DATA_W = CPU_INST_W,
   parameter int PC_W   = CPU_ADDR_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic              load,
   input  logic              drain,
   input  logic [DATA_W-1:0] load_data,
   input  logic [PC_W-1:0]   load_pc,
   output logic [DATA_W-1:0] data,
   output logic [PC_W-1:0]   pc,
   output logic              full
);

   logic [DATA_W-1:0] data_d, data_q;
   logic [PC_W-1:0]   pc_d,   pc_q;
   logic              full_d, full_q;

   always_comb begin
      data_d = data_q;
      pc_d   = pc_q;
      full_d = full_q;
      if (clear) begin
         full_d = 1'b0;
      end else if (load) begin
         data_d = load_data;
         pc_d   = load_pc;
         full_d = 1'b1;
      end else if (drain) begin
         full_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data_q <= '0;
         pc_q   <= '0;
         full_q <= 1'b0;
      end else begin
         data_q <= data_d;
         pc_q   <= pc_d;
         full_q <= full_d;
      end
   end

   assign data = data_q;
   assign pc   = pc_q;
   assign full = full_q;

endmodule : fetch_skid_buf
`default_nettype wire

// File: rtl/inst_fetch.sv
`default_nettype none
// ============================================================================
// Module : inst_fetch
// Brief  : Instruction-fetch initiator for a synchronous single-port ROM with
//          one-cycle read latency. Holds the PC, issues reads, registers the
//          returned instruction with its PC. Supports decode stall through a
//          one-entry skid buffer, and redirect with flush of in-flight reads.
// Ports  : clk, reset               - clock / async active-high reset
//          stall                    - decode cannot accept; hold outputs
//          redirect_valid/_pc       - load new PC and flush
//          rom_ena/rom_addr/rom_data- ROM read interface
//          inst_valid/inst/inst_pc  - registered instruction to decode
// Rev    : 1.0  initial release
// ============================================================================
module inst_fetch
   import cpu_pkg::*;
#(
   parameter int                ADDR_W   = CPU_ADDR_W,
   parameter int                INST_W   = CPU_INST_W,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(CPU_RESET_PC)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              stall,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              rom_ena,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [INST_W-1:0] rom_data,
   output logic              inst_valid,
   output logic [INST_W-1:0] inst,
   output logic [ADDR_W-1:0] inst_pc
);

   logic [ADDR_W-1:0] pc_d,         pc_q;
   logic              req_valid_d,  req_valid_q;
   logic [ADDR_W-1:0] req_pc_d,     req_pc_q;
   logic              inst_valid_d, inst_valid_q;
   logic [INST_W-1:0] inst_d,       inst_q;
   logic [ADDR_W-1:0] inst_pc_d,    inst_pc_q;

   logic              issue;
   logic              skid_load;
   logic              skid_drain;
   logic              skid_full;
   logic [INST_W-1:0] skid_data;
   logic [ADDR_W-1:0] skid_pc;

   // A read is issued only when decode can take the result and no redirect
   // is discarding the current PC.
   assign issue = !stall && !redirect_valid;

   always_comb begin
      pc_d        = pc_q;
      req_pc_d    = req_pc_q;
      req_valid_d = issue;
      if (redirect_valid) begin
         pc_d = redirect_pc;
      end else if (issue) begin
         pc_d     = pc_q + ADDR_W'(1);
         req_pc_d = pc_q;
      end
   end

   // Output register update. Stall only ever overlaps one in-flight read,
   // and no read is issued while stalled, so the skid and a live ROM
   // response are never both pending when stall is low.
   always_comb begin
      inst_valid_d = inst_valid_q;
      inst_d       = inst_q;
      inst_pc_d    = inst_pc_q;
      skid_load    = 1'b0;
      skid_drain   = 1'b0;
      if (redirect_valid) begin
         inst_valid_d = 1'b0;
      end else if (stall) begin
         skid_load = req_valid_q;
      end else if (skid_full) begin
         inst_valid_d = 1'b1;
         inst_d       = skid_data;
         inst_pc_d    = skid_pc;
         skid_drain   = 1'b1;
      end else if (req_valid_q) begin
         inst_valid_d = 1'b1;
         inst_d       = rom_data;
         inst_pc_d    = req_pc_q;
      end else begin
         inst_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_q         <= RESET_PC;
         req_valid_q  <= 1'b0;
         req_pc_q     <= '0;
         inst_valid_q <= 1'b0;
         inst_q       <= INST_W'(NOP_INST);
         inst_pc_q    <= '0;
      end else begin
         pc_q         <= pc_d;
         req_valid_q  <= req_valid_d;
         req_pc_q     <= req_pc_d;
         inst_valid_q <= inst_valid_d;
         inst_q       <= inst_d;
         inst_pc_q    <= inst_pc_d;
      end
   end

   fetch_skid_buf #(
      .DATA_W (INST_W),
      .PC_W   (ADDR_W)
   ) u_skid (
      .clk       (clk),
      .reset     (reset),
      .clear     (redirect_valid),
      .load      (skid_load),
      .drain     (skid_drain),
      .load_data (rom_data),
      .load_pc   (req_pc_q),
      .data      (skid_data),
      .pc        (skid_pc),
      .full      (skid_full)
   );

   assign rom_ena    = !reset && issue;
   assign rom_addr   = pc_q;
   assign inst_valid = inst_valid_q;
   assign inst       = inst_q;
   assign inst_pc    = inst_pc_q;

endmodule : inst_fetch
`default_nettype wire

// File: tb/tb_inst_fetch.sv
`default_nettype none
// ============================================================================
// Module : tb_inst_fetch
// Brief  : Directed self-checking bench for inst_fetch. The ROM model returns
//          {16'hA5A5, addr} one cycle after an enabled read.
// Rev    : 1.0  initial release
// ============================================================================
module tb_inst_fetch;

   localparam int ADDR_W = 16;
   localparam int INST_W = 32;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              stall = 1'b0;
   logic              redirect_valid = 1'b0;
   logic [ADDR_W-1:0] redirect_pc = '0;
   logic              rom_ena;
   logic [ADDR_W-1:0] rom_addr;
   logic [INST_W-1:0] rom_data = '0;
   logic              inst_valid;
   logic [INST_W-1:0] inst;
   logic [ADDR_W-1:0] inst_pc;

   int n_cmp = 0;
   int n_err = 0;

   inst_fetch #(
      .ADDR_W   (ADDR_W),
      .INST_W   (INST_W),
      .RESET_PC (16'h0000)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .stall          (stall),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .rom_ena        (rom_ena),
      .rom_addr       (rom_addr),
      .rom_data       (rom_data),
      .inst_valid     (inst_valid),
      .inst           (inst),
      .inst_pc        (inst_pc)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (rom_ena) rom_data <= {16'hA5A5, rom_addr};
   end

   task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance one cycle; inputs are driven and outputs sampled mid-cycle.
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic expect_inst(input string tag, input logic [15:0] pc);
      #1;
      chk({tag, ".valid"}, 48'(inst_valid), 48'd1);
      chk({tag, ".pc"},    48'(inst_pc),    48'(pc));
      chk({tag, ".inst"},  48'(inst),       48'({16'hA5A5, pc}));
   endtask

   task automatic expect_idle(input string tag);
      #1;
      chk({tag, ".valid"}, 48'(inst_valid), 48'd0);
   endtask

   initial begin
      // ---------------- reset state
      #1 reset = 1'b1;
      tick();
      tick();
      #1;
      chk("rst.valid",   48'(inst_valid), 48'd0);
      chk("rst.inst",    48'(inst),       48'd0);
      chk("rst.inst_pc", 48'(inst_pc),    48'd0);
      chk("rst.rom_ena", 48'(rom_ena),    48'd0);
      chk("rst.addr",    48'(rom_addr),   48'd0);

      // ---------------- 1: release -> cycle 0 issues pc 0, valid in cycle 2
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("c0.rom_ena", 48'(rom_ena),  48'd1);
      chk("c0.addr",    48'(rom_addr), 48'd0);
      chk("c0.valid",   48'(inst_valid), 48'd0);
      tick(); expect_idle("c1");
      tick(); expect_inst("c2", 16'd0);
      tick(); expect_inst("c3", 16'd1);
      tick(); expect_inst("c4", 16'd2);

      // ---------------- 2: one-cycle stall while inst_pc=2
      stall = 1'b1;
      #1 chk("st1.rom_ena", 48'(rom_ena), 48'd0);
      expect_inst("st1.hold", 16'd2);
      tick(); stall = 1'b0;
      expect_inst("st1.hold2", 16'd2);
      tick(); expect_inst("c6", 16'd3);
      tick(); expect_inst("c7", 16'd4);
      tick(); expect_inst("c8", 16'd5);
      tick(); expect_inst("c9", 16'd6);
      tick(); expect_inst("c10", 16'd7);

      // ---------------- 3: five-cycle stall while inst_pc=7
      stall = 1'b1;
      for (int i = 0; i < 5; i++) begin
         if (i != 0) tick();
         #1 chk("st5.rom_ena", 48'(rom_ena), 48'd0);
         expect_inst("st5.hold", 16'd7);
      end
      tick(); stall = 1'b0;
      expect_inst("st5.rel", 16'd7);
      tick(); expect_inst("st5.pc8", 16'd8);
      tick(); expect_inst("st5.pc9", 16'd9);

      // ---------------- 4: redirect to 0x0040, no stall
      tick();
      expect_inst("rd.t", 16'd10);
      redirect_valid = 1'b1;
      redirect_pc    = 16'h0040;
      #1 chk("rd.rom_ena", 48'(rom_ena), 48'd0);
      tick(); redirect_valid = 1'b0;
      expect_idle("rd.t1");
      #1 chk("rd.t1.addr", 48'(rom_addr), 48'h0040);
      tick(); expect_idle("rd.t2");
      tick(); expect_inst("rd.t3", 16'h0040);
      tick(); expect_inst("rd.t4", 16'h0041);

      // ---------------- 5: redirect to 0x0100 while stalled with skid full
      tick(); expect_inst("rs.pre", 16'h0042);
      stall = 1'b1;
      tick(); expect_inst("rs.hold", 16'h0042);
      redirect_valid = 1'b1;
      redirect_pc    = 16'h0100;
      tick(); redirect_valid = 1'b0;
      expect_idle("rs.flushed");
      #1 chk("rs.rom_ena", 48'(rom_ena), 48'd0);
      tick(); stall = 1'b0;
      expect_idle("rs.rel");
      #1 chk("rs.addr", 48'(rom_addr), 48'h0100);
      tick(); expect_idle("rs.rel1");
      tick(); expect_inst("rs.pc100", 16'h0100);
      tick(); expect_inst("rs.pc101", 16'h0101);

      // ---------------- 6: redirect to 0xFFFE, PC wraps
      tick();
      redirect_valid = 1'b1;
      redirect_pc    = 16'hFFFE;
      tick(); redirect_valid = 1'b0;
      tick();
      tick(); expect_inst("wr.fffe", 16'hFFFE);
      #1 chk("wr.addr", 48'(rom_addr), 48'h0000);
      tick(); expect_inst("wr.ffff", 16'hFFFF);
      tick(); expect_inst("wr.0000", 16'h0000);
      tick(); expect_inst("wr.0001", 16'h0001);

      // ---------------- 7: reset mid-stall with skid full
      tick(); expect_inst("rz.pre", 16'h0002);
      stall = 1'b1;
      tick(); expect_inst("rz.hold", 16'h0002);
      reset = 1'b1;
      #1;
      chk("rz.valid",   48'(inst_valid), 48'd0);
      chk("rz.inst",    48'(inst),       48'd0);
      chk("rz.inst_pc", 48'(inst_pc),    48'd0);
      chk("rz.rom_ena", 48'(rom_ena),    48'd0);
      chk("rz.addr",    48'(rom_addr),   48'd0);
      tick();
      stall = 1'b0;
      reset = 1'b0;
      #1 chk("rz.c0.rom_ena", 48'(rom_ena), 48'd1);
      tick(); expect_idle("rz.c1");
      tick(); expect_inst("rz.c2", 16'd0);
      tick(); expect_inst("rz.c3", 16'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   // Absolute time bound so the run always ends.
   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule : tb_inst_fetch
`default_nettype wire
